alarm_ring: RTL and testbench



---
 rtl/alarm_ring.sv | 201 ++++++++++++++++++++
 tb/tb_alarm_ring.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ring.sv
// Alarm ring and hourly chime controller: compares the running BCD time with the
// stored alarm, rings for RING_SEC seconds on a match and chimes the hour count on whole hours.
module alarm_ring #(
    parameter int TONE_DIV     = 25000,
    parameter int RING_SEC     = 60,
    parameter int BEEP_ON_CYC  = 10000000,
    parameter int BEEP_OFF_CYC = 15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_minute,
    input  logic [7:0] cur_second,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    input  logic       alarm_en,
    input  logic       key_stop,
    output logic       buzzer,
    output logic       ringing,
    output logic       chiming
);

    localparam int SEC_W   = $clog2(RING_SEC + 1);
    localparam int CYC_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int TONE_W  = $clog2(TONE_DIV + 1);

    localparam logic [SEC_W-1:0]  SEC_LOAD  = SEC_W'(RING_SEC);
    localparam logic [CYC_W-1:0]  ON_LAST   = CYC_W'(BEEP_ON_CYC - 1);
    localparam logic [CYC_W-1:0]  OFF_LAST  = CYC_W'(BEEP_OFF_CYC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RING  = 2'd1,
        ST_CHIME = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [3:0]        beep_q, beep_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              phase_on_q, phase_on_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic              buzzer_q, buzzer_d;

    logic key_s1, key_s2, key_s3;
    logic stop_pulse;
    logic a_match, h_match, a_d, h_d, a_evt, h_evt;
    logic gate_q, gate_d;

    // Beep count on a 12-hour dial: hour 0 and 12 both give twelve beeps.
    function automatic logic [3:0] chime_count(input logic [7:0] h);
        logic [6:0] bin;
        logic [6:0] m;
        bin = 7'(h[7:4]) * 7'd10 + 7'(h[3:0]);
        m   = bin % 7'd12;
        chime_count = (m == 7'd0) ? 4'd12 : m[3:0];
    endfunction

    assign stop_pulse = key_s3 & ~key_s2;

    assign a_match = alarm_en & (cur_hour == alarm_hour) & (cur_minute == alarm_minute)
                   & (cur_second == 8'h00);
    assign h_match = (cur_minute == 8'h00) & (cur_second == 8'h00);
    assign a_evt   = a_match & ~a_d;
    assign h_evt   = h_match & ~h_d;

    // Match history resets high so a match already present at reset release is not an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_s3 <= 1'b1;
            a_d    <= 1'b1;
            h_d    <= 1'b1;
        end else begin
            key_s1 <= key_stop;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
            a_d    <= a_match;
            h_d    <= h_match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sec_q      <= '0;
            beep_q     <= '0;
            cyc_q      <= '0;
            phase_on_q <= 1'b0;
            tone_q     <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            beep_q     <= beep_d;
            cyc_q      <= cyc_d;
            phase_on_q <= phase_on_d;
            tone_q     <= tone_d;
            buzzer_q   <= buzzer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        beep_d     = beep_q;
        cyc_d      = cyc_q;
        phase_on_d = phase_on_q;
        case (state_q)
            ST_IDLE: begin
                if (stop_pulse) begin
                    state_d = ST_IDLE;
                end else if (a_evt) begin
                    state_d = ST_RING;
                    sec_d   = SEC_LOAD;
                end else if (h_evt) begin
                    state_d    = ST_CHIME;
                    beep_d     = chime_count(cur_hour);
                    phase_on_d = 1'b1;
                    cyc_d      = '0;
                end
            end
            ST_RING: begin
                if (stop_pulse || !alarm_en) begin
                    state_d = ST_IDLE;
                    sec_d   = '0;
                end else if (tick_1hz) begin
                    if (sec_q <= SEC_W'(1)) begin
                        state_d = ST_IDLE;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q - SEC_W'(1);
                    end
                end
            end
            ST_CHIME: begin
                if (stop_pulse) begin
                    state_d    = ST_IDLE;
                    beep_d     = '0;
                    cyc_d      = '0;
                    phase_on_d = 1'b0;
                end else if (a_evt) begin
                    state_d    = ST_RING;
                    sec_d      = SEC_LOAD;
                    beep_d     = '0;
                    cyc_d      = '0;
                    phase_on_d = 1'b0;
                end else if (phase_on_q) begin
                    if (cyc_q == ON_LAST) begin
                        cyc_d      = '0;
                        phase_on_d = 1'b0;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end else if (cyc_q == OFF_LAST) begin
                    cyc_d = '0;
                    if (beep_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        beep_d  = '0;
                    end else begin
                        beep_d     = beep_q - 4'd1;
                        phase_on_d = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gate_q = (state_q == ST_RING) | ((state_q == ST_CHIME) & phase_on_q);
    assign gate_d = (state_d == ST_RING) | ((state_d == ST_CHIME) & phase_on_d);

    // Ungating is taken from the next state so the buzzer is silent on the first cycle out
    // of a tone; the divider restarts from zero on the first gated cycle.
    always_comb begin
        tone_d   = tone_q;
        buzzer_d = buzzer_q;
        if (!gate_d) begin
            tone_d   = '0;
            buzzer_d = 1'b0;
        end else if (!gate_q) begin
            tone_d = '0;
        end else if (tone_q == TONE_LAST) begin
            tone_d   = '0;
            buzzer_d = ~buzzer_q;
        end else begin
            tone_d = tone_q + TONE_W'(1);
        end
    end

    assign buzzer  = buzzer_q;
    assign ringing = (state_q == ST_RING);
    assign chiming = (state_q == ST_CHIME);

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring: stimulus pushes per-cycle expected {ringing, chiming, buzzer}
// into a queue and a negedge monitor pops and compares them.
module tb_alarm_ring;

    localparam int TONE_DIV = 4;
    localparam int RING_SEC = 3;
    localparam int ON_CYC   = 8;
    localparam int OFF_CYC  = 8;
    localparam int BEEP_CYC = ON_CYC + OFF_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [7:0] cur_hour, cur_minute, cur_second;
    logic [7:0] alarm_hour, alarm_minute;
    logic       alarm_en;
    logic       key_stop;
    logic       buzzer, ringing, chiming;

    alarm_ring #(
        .TONE_DIV    (TONE_DIV),
        .RING_SEC    (RING_SEC),
        .BEEP_ON_CYC (ON_CYC),
        .BEEP_OFF_CYC(OFF_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .cur_hour    (cur_hour),
        .cur_minute  (cur_minute),
        .cur_second  (cur_second),
        .alarm_hour  (alarm_hour),
        .alarm_minute(alarm_minute),
        .alarm_en    (alarm_en),
        .key_stop    (key_stop),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .chiming     (chiming)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {cycle[31:0], ringing, chiming, buzzer}
    logic [34:0] exp_q[$];
    string       name_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        logic [34:0] e;
        string       nm;
        while (exp_q.size() > 0 && int'(exp_q[0][34:3]) <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (int'(e[34:3]) != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d",
                         nm, int'(e[34:3]), cyc);
            end else if ({ringing, chiming, buzzer} !== e[2:0]) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: ring/chime/buzzer got %b required %b",
                         nm, cyc, {ringing, chiming, buzzer}, e[2:0]);
            end
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hour   = h;
        cur_minute = m;
        cur_second = s;
    endtask

    task automatic tick_at(input int c);
        wait_until(c);
        tick_1hz = 1'b1;
        next_cycle();
        tick_1hz = 1'b0;
    endtask

    task automatic push_exp(input int c, input logic r, input logic ch, input logic b,
                            input string nm);
        exp_q.push_back({c[31:0], r, ch, b});
        name_q.push_back(nm);
    endtask

    task automatic push_idle(input int start, input int len, input string nm);
        for (int i = 0; i < len; i++) push_exp(start + i, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic push_ring(input int start, input int len, input string nm);
        for (int i = 0; i < len; i++)
            push_exp(start + i, 1'b1, 1'b0, ((i / TONE_DIV) % 2) == 1, nm);
    endtask

    task automatic push_chime(input int start, input int len, input string nm);
        int p;
        for (int j = 0; j < len; j++) begin
            p = j % BEEP_CYC;
            push_exp(start + j, 1'b0, 1'b1, (p < ON_CYC) && (((p / TONE_DIV) % 2) == 1), nm);
        end
    endtask

    // Stimulus
    initial begin
        int k;
        rst          = 1'b1;
        tick_1hz     = 1'b0;
        key_stop     = 1'b1;
        alarm_en     = 1'b0;
        alarm_hour   = 8'h07;
        alarm_minute = 8'h30;
        set_time(8'h00, 8'h00, 8'h00);
        repeat (3) next_cycle();

        // Reset state, and a whole hour held across reset release must not chime
        rst = 1'b0;
        push_idle(cyc, 8, "reset_idle");
        wait_until(cyc + 8);

        // Alarm ring, expiring after the third tick
        alarm_en = 1'b1;
        set_time(8'h07, 8'h29, 8'h59);
        repeat (2) next_cycle();
        k = cyc;
        set_time(8'h07, 8'h30, 8'h00);
        push_idle(k, 1, "ring_pre");
        push_ring(k + 1, 12, "ring_run");
        push_idle(k + 13, 4, "ring_expired");
        tick_at(k + 4);
        tick_at(k + 8);
        tick_at(k + 12);
        wait_until(k + 17);

        // Stop key mid-ring, then held match must not re-ring
        set_time(8'h07, 8'h30, 8'h01);
        next_cycle();
        k = cyc;
        set_time(8'h07, 8'h30, 8'h00);
        push_ring(k + 1, 8, "stop_ring");
        push_idle(k + 9, 12, "stop_idle");
        wait_until(k + 6);
        key_stop = 1'b0;
        repeat (5) next_cycle();
        key_stop = 1'b1;
        wait_until(k + 21);

        // alarm_en dropped mid-ring
        set_time(8'h07, 8'h30, 8'h01);
        next_cycle();
        k = cyc;
        set_time(8'h07, 8'h30, 8'h00);
        push_ring(k + 1, 3, "en_drop_ring");
        push_idle(k + 4, 5, "en_drop_idle");
        wait_until(k + 3);
        alarm_en = 1'b0;
        wait_until(k + 9);

        // Disabled alarm at its time does not ring
        alarm_hour   = 8'h09;
        alarm_minute = 8'h15;
        set_time(8'h09, 8'h14, 8'h59);
        next_cycle();
        k = cyc;
        set_time(8'h09, 8'h15, 8'h00);
        push_idle(k, 10, "disabled_alarm");
        wait_until(k + 10);

        // Hourly chime at 15:00 -> 3 beeps
        set_time(8'h14, 8'h59, 8'h59);
        next_cycle();
        k = cyc;
        set_time(8'h15, 8'h00, 8'h00);
        push_idle(k, 1, "chime15_pre");
        push_chime(k + 1, 3 * BEEP_CYC, "chime15_run");
        push_idle(k + 1 + 3 * BEEP_CYC, 5, "chime15_end");
        wait_until(k + 6 + 3 * BEEP_CYC);

        // Midnight chime -> 12 beeps
        set_time(8'h23, 8'h59, 8'h59);
        next_cycle();
        k = cyc;
        set_time(8'h00, 8'h00, 8'h00);
        push_idle(k, 1, "chime00_pre");
        push_chime(k + 1, 12 * BEEP_CYC, "chime00_run");
        push_idle(k + 1 + 12 * BEEP_CYC, 3, "chime00_end");
        wait_until(k + 4 + 12 * BEEP_CYC);

        // Alarm on a whole hour rings instead of chiming
        alarm_hour   = 8'h08;
        alarm_minute = 8'h00;
        alarm_en     = 1'b1;
        set_time(8'h07, 8'h59, 8'h59);
        next_cycle();
        k = cyc;
        set_time(8'h08, 8'h00, 8'h00);
        push_idle(k, 1, "hour_alarm_pre");
        push_ring(k + 1, 6, "hour_alarm_ring");
        push_idle(k + 7, 6, "hour_alarm_no_chime");
        wait_until(k + 6);
        alarm_en = 1'b0;
        wait_until(k + 13);

        // Reset mid-chime with the whole hour still present
        set_time(8'h10, 8'h59, 8'h59);
        next_cycle();
        k = cyc;
        set_time(8'h11, 8'h00, 8'h00);
        push_idle(k, 1, "rst_chime_pre");
        push_chime(k + 1, 11, "rst_chime_run");
        push_idle(k + 12, 12, "rst_chime_idle");
        wait_until(k + 11);
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        wait_until(k + 24);

        // Next whole hour, 13:00 -> a single beep
        set_time(8'h12, 8'h59, 8'h59);
        next_cycle();
        k = cyc;
        set_time(8'h13, 8'h00, 8'h00);
        push_idle(k, 1, "chime13_pre");
        push_chime(k + 1, BEEP_CYC, "chime13_run");
        push_idle(k + 1 + BEEP_CYC, 4, "chime13_end");
        wait_until(k + 5 + BEEP_CYC);

        // Final report
        wait_until(cyc + 2);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
